fetch_unit: RTL and testbench

- Instruction-fetch and program-counter stage, directly upstream of the single-cycle controller.
- Owns the PC and issues requests to instruction memory with a ready handshake.
- Holds each fetched instruction and splits it into opcode/func/rs/rt/rd/imm for the controller and datapath.
- Computes the next PC from the controller's redirect/source selects. Stalls on datapath request; stops on a HALT opcode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_next_pc_logic.sv | 43 ++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode constants and FSM state encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b011000;
  localparam logic [5:0] OP_JR    = 6'b011001;
  localparam logic [5:0] OP_JAL   = 6'b011010;
  localparam logic [5:0] OP_BEQ   = 6'b011011;
  localparam logic [5:0] OP_BNE   = 6'b011100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: sequential, register target, jump or branch.
module next_pc_logic #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_plus1,
  input  logic [31:0]     instr,
  input  logic            pc_redirect,
  input  logic            pc_src,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] next_pc
);
  import fetch_pkg::*;

  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] branch_target;

  // Jumps keep the upper bits of pc+1 above the 26-bit index field.
  generate
    if (PC_W == 26) begin : g_jump_narrow
      assign jump_target = instr[25:0];
    end else begin : g_jump_wide
      assign jump_target = {pc_plus1[PC_W-1:26], instr[25:0]};
    end
  endgenerate

  assign branch_target = pc_plus1 + {{(PC_W-16){instr[15]}}, instr[15:0]};

  always_comb begin
    next_pc = pc_plus1;
    if (pc_redirect) begin
      if (!pc_src) begin
        next_pc = reg_target;
      end else begin
        case (instr[31:26])
          OP_J, OP_JAL:     next_pc = jump_target;
          OP_BEQ, OP_BNE:   next_pc = branch_target;
          default:          next_pc = pc_plus1;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / PC stage: fetches over a ready handshake, holds the word
// for the controller during EXEC, then advances the PC.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// FETCH | imem_req high at pc, waiting for imem_ready
// EXEC  | instr valid for the controller; waits out exec_stall
// HALT  | HALT opcode fetched; only reset leaves
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic [5:0]      func,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [15:0]     imm,
  output logic            instr_valid,
  input  logic            exec_stall,
  input  logic            pc_redirect,
  input  logic            pc_src,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            halted
);
  import fetch_pkg::*;

  generate
    if (PC_W < 26 || PC_W > 32) begin : g_bad_pc_w
      $error("fetch_unit: PC_W must be within 26..32");
    end
  endgenerate

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] next_pc;

  assign pc_plus1  = pc + PC_W'(1);
  assign imem_addr = pc;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign func   = instr[5:0];
  assign imm    = instr[15:0];

  next_pc_logic #(
    .PC_W (PC_W)
  ) u_next_pc (
    .pc_plus1    (pc_plus1),
    .instr       (instr),
    .pc_redirect (pc_redirect),
    .pc_src      (pc_src),
    .reg_target  (reg_target),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && imem_ready) begin
        instr <= imem_rdata;
      end
      // Redirect selects only matter at the single EXEC cycle that retires.
      if (state == EXEC && !exec_stall) begin
        pc <= next_pc;
      end
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_next = (imem_rdata[31:26] == OP_HALT) ? HALT : EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!exec_stall) begin
          state_next = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, next-PC selection, stall and halt.
module tb_fetch_unit;

  localparam int PC_W = 32;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [5:0]      opcode;
  logic [5:0]      func;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [15:0]     imm;
  logic            instr_valid;
  logic            exec_stall;
  logic            pc_redirect;
  logic            pc_src;
  logic [PC_W-1:0] reg_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic            halted;

  logic [31:0] mem [0:511];
  logic        ready_en;
  int          n_vec;
  int          n_miss;

  fetch_unit #(
    .PC_W     (PC_W),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .instr_valid (instr_valid),
    .exec_stall  (exec_stall),
    .pc_redirect (pc_redirect),
    .pc_src      (pc_src),
    .reg_target  (reg_target),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ready = ready_en;
  assign imem_rdata = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 32'h0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_exec(input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_vec("exec_reached", {31'd0, instr_valid}, 32'd1);
  endtask

  // Retire the current EXEC cycle with the given redirect selects.
  task automatic retire(input logic redir, input logic src, input logic [PC_W-1:0] tgt);
    pc_redirect = redir;
    pc_src      = src;
    reg_target  = tgt;
    @(negedge clk);
    pc_redirect = 1'b0;
    pc_src      = 1'b0;
    reg_target  = '0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h00F] = 32'h6000_0010;  // J 0x10
    mem[9'h010] = 32'h6C00_FFFE;  // BEQ imm=-2
    mem[9'h011] = 32'h6000_0020;  // J 0x20
    mem[9'h020] = 32'h6800_0100;  // JAL 0x100
    mem[9'h100] = 32'h6400_0000;  // JR
    mem[9'h044] = 32'h0022_1820;  // R-type rs=1 rt=2 rd=3 func=0x20
    mem[9'h045] = 32'h7000_0003;  // BNE imm=+3
    mem[9'h04A] = 32'hFC00_0000;  // HALT

    rst         = 1'b1;
    ready_en    = 1'b1;
    exec_stall  = 1'b0;
    pc_redirect = 1'b0;
    pc_src      = 1'b0;
    reg_target  = '0;

    repeat (2) @(negedge clk);
    check_vec("rst_pc", pc, 32'h0);
    check_vec("rst_instr", instr, 32'h0);
    check_vec("rst_req", {31'd0, imem_req}, 32'd0);
    check_vec("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_vec("rst_halted", {31'd0, halted}, 32'd0);

    rst = 1'b0;
    @(negedge clk);
    check_vec("req_rise", {31'd0, imem_req}, 32'd1);
    check_vec("valid_low_fetch", {31'd0, instr_valid}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_vec("seq_valid", {31'd0, instr_valid}, 32'd1);
      check_vec("seq_pc", pc, i);
      @(negedge clk);
      check_vec("seq_req", {31'd0, imem_req}, 32'd1);
      check_vec("seq_pc_next", pc, i + 1);
    end

    // Now in FETCH at pc=4; advance to EXEC at pc=4 and starve the next fetch.
    @(negedge clk);
    ready_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_vec("wait_addr", imem_addr, 32'h5);
      check_vec("wait_req", {31'd0, imem_req}, 32'd1);
      check_vec("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    ready_en = 1'b1;
    @(negedge clk);
    check_vec("ready_valid", {31'd0, instr_valid}, 32'd1);
    check_vec("ready_pc", pc, 32'h5);

    retire(1'b1, 1'b0, 32'h10);
    check_vec("jr_to_10", pc, 32'h10);
    wait_exec(8);
    check_vec("beq_instr", instr, 32'h6C00_FFFE);
    check_vec("beq_opcode", {26'd0, opcode}, 32'h1B);
    check_vec("beq_imm", {16'd0, imm}, 32'hFFFE);
    check_vec("beq_pc_plus1", pc_plus1, 32'h11);
    retire(1'b1, 1'b1, 32'h0);
    check_vec("beq_taken", pc, 32'h0F);

    wait_exec(8);
    check_vec("j_opcode", {26'd0, opcode}, 32'h18);
    retire(1'b1, 1'b1, 32'h0);
    check_vec("j_to_10", pc, 32'h10);

    wait_exec(8);
    retire(1'b0, 1'b1, 32'h0);
    check_vec("beq_not_taken", pc, 32'h11);

    wait_exec(8);
    retire(1'b1, 1'b1, 32'h0);
    check_vec("j_to_20", pc, 32'h20);

    wait_exec(8);
    check_vec("jal_opcode", {26'd0, opcode}, 32'h1A);
    check_vec("jal_link", pc_plus1, 32'h21);
    retire(1'b1, 1'b1, 32'h0);
    check_vec("jal_to_100", pc, 32'h100);

    wait_exec(8);
    retire(1'b1, 1'b0, 32'h44);
    check_vec("jr_to_44", pc, 32'h44);

    wait_exec(8);
    check_vec("rtype_rs", {27'd0, rs}, 32'd1);
    check_vec("rtype_rt", {27'd0, rt}, 32'd2);
    check_vec("rtype_rd", {27'd0, rd}, 32'd3);
    check_vec("rtype_func", {26'd0, func}, 32'h20);
    retire(1'b1, 1'b1, 32'h0);
    check_vec("rtype_src1_seq", pc, 32'h45);

    wait_exec(8);
    retire(1'b1, 1'b1, 32'h0);
    check_vec("bne_fwd", pc, 32'h49);

    wait_exec(8);
    exec_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_vec("stall_valid", {31'd0, instr_valid}, 32'd1);
      check_vec("stall_pc", pc, 32'h49);
      check_vec("stall_req", {31'd0, imem_req}, 32'd0);
    end
    exec_stall = 1'b0;
    @(negedge clk);
    check_vec("stall_release_pc", pc, 32'h4A);
    check_vec("stall_release_req", {31'd0, imem_req}, 32'd1);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_vec("halt_flag", {31'd0, halted}, 32'd1);
      check_vec("halt_valid", {31'd0, instr_valid}, 32'd0);
      check_vec("halt_req", {31'd0, imem_req}, 32'd0);
      check_vec("halt_pc", pc, 32'h4A);
    end
    check_vec("halt_instr", instr, 32'hFC00_0000);

    rst = 1'b1;
    @(negedge clk);
    check_vec("rerst_pc", pc, 32'h0);
    check_vec("rerst_halted", {31'd0, halted}, 32'd0);
    check_vec("rerst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_vec("resume_req", {31'd0, imem_req}, 32'd1);
    check_vec("resume_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
